stop_watch_dp_param: RTL
========================

// Module: stop_watch_dp_param
// PURPOSE
//  Parametrised successor to the stopwatch datapath: hh:mm:ss:cc time counter, up or down.
//  Adds a synchronous run enable (no gated clock), a preset load and countdown expiry.
//  Sits between the button/FSM control unit and the FND display mux.
//  Optional lap-capture registers.
// PARAMETERS
//  CLK_HZ    100_000_000  input clock frequency in Hz
//  TICK_HZ   100          centisecond tick rate; prescaler DIV = CLK_HZ/TICK_HZ (integer, >=2)
//  HOUR_MAX  24           hour field modulus (1..32)
// PORTS
//  clk       in   1  system clock
//  rst       in   1  reset, asynchronous, active-low
//  run       in   1  level; 1 = count, 0 = hold (prescaler and fields hold, not cleared)
//  clear     in   1  sync pulse; zero prescaler and all fields
//  dir       in   1  0 = count up (stopwatch), 1 = count down (timer)
//  load      in   1  sync pulse; load ld_* into fields, zero prescaler
//  ld_msec   in   7  preset centiseconds
//  ld_sec    in   6  preset seconds
//  ld_min    in   6  preset minutes
//  ld_hour   in   5  preset hours
//  lap       in   1  sync pulse; capture current time (STOPWATCH_LAP_EN only)
//  msec      out  7  centiseconds 0..99
//  sec       out  6  seconds 0..59
//  min       out  6  minutes 0..59
//  hour      out  5  hours 0..HOUR_MAX-1
//  lap_msec/lap_sec/lap_min/lap_hour  out 7/6/6/5  captured lap time
//  wrap      out  1  1-cycle pulse: up-count rolled HOUR_MAX-1:59:59:99 -> 0
//  expired   out  1  1-cycle pulse: down-count reached 0:00:00:00
// BEHAVIOUR
//  - Reset: all outputs, lap regs and prescaler = 0. Every output is a register.
//  - Prescaler: counts 0..DIV-1 while run=1; tick asserts combinationally on DIV-1.
//  - Fields update on the edge where tick=1; full carry/borrow ripple resolves in that same edge.
//  - Up: msec 99->0 carries sec; sec/min 59->0 carry; hour HOUR_MAX-1->0 wraps and pulses wrap.
//  - Down: msec 0->99 borrows; sec/min 0->59; hour borrows only when it is nonzero.
//  - Down at all-zero: saturate, no borrow. expired pulses once on the edge fields become 0.
//    Holds while run=1; never re-pulses until fields change via load or up-count.
//  - Down tick with fields already zero (e.g. after clear): no change, no expired.
//  - Priority per cycle: clear > load > tick. clear/load also zero the prescaler.
//    A tick coinciding with clear/load is discarded.
//  - load clamps out-of-range values: msec>99->99, sec/min>59->59, hour>=HOUR_MAX->HOUR_MAX-1.
//  - dir changes take effect on the next tick; no prescaler reset.
//  - Async reset asserted mid-count clears immediately. Counting resumes on the first clk
//    edge after release, if run=1.
// CONFIGURATION
//  STOPWATCH_LAP_EN defined:
//    - lap pulse latches the pre-update fields of that cycle into lap_*.
//    - lap takes priority over nothing; it coexists with clear/load/tick.
//    - clear also zeroes lap_*.
//  STOPWATCH_LAP_EN undefined:
//    - lap input ignored; lap_* tied to 0; no lap registers synthesised.
// TESTING (sim with CLK_HZ=1000, TICK_HZ=100 -> DIV=10)
//  - rst=0 then 1, run=1 for 1000 clk, dir=0 -> msec=0, sec=1; wrap=0, expired=0.
//  - load 23:59:59:98 (HOUR_MAX=24), run=1 up, 20 clk ->
//    ticks to :99, then 0:00:00:00 with wrap high exactly 1 cycle.
//  - load 0:00:01:00, dir=1, run=1 -> 0:00:00:99 after 10 clk; 0:00:00:00 after 1000 clk
//    with one expired pulse; stays 0 for a further 100 clk.
//  - run=1 5 clk, run=0 50 clk, run=1 5 clk -> msec=1 at the 10th enabled clk (prescaler held).
//  - load ld_sec=63, ld_hour=30 -> sec=59, hour=23; clear+load same cycle -> all 0.
//  - LAP_EN: lap at msec=42 -> lap_msec=42 while msec keeps counting; undefined -> lap_*=0.

Source files
------------

// File: rtl/stop_watch_dp_param.sv
// hh:mm:ss:cc stopwatch/timer datapath with run enable, preset load and countdown expiry.
// Optional lap-capture registers are built when STOPWATCH_LAP_EN is defined.

module stop_watch_field #(
  parameter int W   = 7,
  parameter int MOD = 100
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt,
  output logic         top,
  output logic         zero
);
  localparam logic [W-1:0] TOP_VAL = W'(MOD - 1);

  always_comb begin
    top  = (val == TOP_VAL);
    zero = (val == '0);
    nxt  = val;
    if (inc)      nxt = top  ? '0      : val + W'(1);
    else if (dec) nxt = zero ? TOP_VAL : val - W'(1);
  end
endmodule

module stop_watch_dp_param #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 100,
  parameter int HOUR_MAX = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic       dir,
  input  logic       load,
  input  logic [6:0] ld_msec,
  input  logic [5:0] ld_sec,
  input  logic [5:0] ld_min,
  input  logic [4:0] ld_hour,
  input  logic       lap,
  output logic [6:0] msec,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [6:0] lap_msec,
  output logic [5:0] lap_sec,
  output logic [5:0] lap_min,
  output logic [4:0] lap_hour,
  output logic       wrap,
  output logic       expired
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
  localparam logic [4:0]    HOUR_TOP  = 5'(HOUR_MAX - 1);

  logic [PW-1:0] presc;
  logic          tick;

  logic [6:0] msec_nxt;
  logic [5:0] sec_nxt, min_nxt;
  logic [4:0] hour_nxt;
  logic msec_top, sec_top, min_top, hour_top;
  logic msec_z, sec_z, min_z, hour_z;
  logic all_zero;
  logic inc_msec, inc_sec, inc_min, inc_hour;
  logic dec_msec, dec_sec, dec_min, dec_hour;
  logic up_wrap, dn_expire;

  logic [6:0] cl_msec;
  logic [5:0] cl_sec, cl_min;
  logic [4:0] cl_hour;

  assign tick     = run && (presc == PRESC_TOP);
  assign all_zero = msec_z && sec_z && min_z && hour_z;

  // Carry/borrow ripple resolves combinationally so every field settles on the tick edge.
  assign inc_msec = tick && !dir;
  assign inc_sec  = inc_msec && msec_top;
  assign inc_min  = inc_sec  && sec_top;
  assign inc_hour = inc_min  && min_top;
  assign up_wrap  = inc_hour && hour_top;

  // A down tick on an all-zero time is a no-op, so the hour never underflows.
  assign dec_msec  = tick && dir && !all_zero;
  assign dec_sec   = dec_msec && msec_z;
  assign dec_min   = dec_sec  && sec_z;
  assign dec_hour  = dec_min  && min_z;
  assign dn_expire = dec_msec && hour_z && min_z && sec_z && (msec == 7'd1);

  stop_watch_field #(.W(7), .MOD(100)) u_msec (
    .val(msec), .inc(inc_msec), .dec(dec_msec), .nxt(msec_nxt), .top(msec_top), .zero(msec_z));
  stop_watch_field #(.W(6), .MOD(60)) u_sec (
    .val(sec), .inc(inc_sec), .dec(dec_sec), .nxt(sec_nxt), .top(sec_top), .zero(sec_z));
  stop_watch_field #(.W(6), .MOD(60)) u_min (
    .val(min), .inc(inc_min), .dec(dec_min), .nxt(min_nxt), .top(min_top), .zero(min_z));
  stop_watch_field #(.W(5), .MOD(HOUR_MAX)) u_hour (
    .val(hour), .inc(inc_hour), .dec(dec_hour), .nxt(hour_nxt), .top(hour_top), .zero(hour_z));

  always_comb begin
    cl_msec = (ld_msec > 7'd99) ? 7'd99 : ld_msec;
    cl_sec  = (ld_sec  > 6'd59) ? 6'd59 : ld_sec;
    cl_min  = (ld_min  > 6'd59) ? 6'd59 : ld_min;
    cl_hour = (32'(ld_hour) >= HOUR_MAX) ? HOUR_TOP : ld_hour;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (clear || load) begin
      presc <= '0;
    end else if (run) begin
      presc <= tick ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msec    <= '0;
      sec     <= '0;
      min     <= '0;
      hour    <= '0;
      wrap    <= 1'b0;
      expired <= 1'b0;
    end else begin
      wrap    <= 1'b0;
      expired <= 1'b0;
      if (clear) begin
        msec <= '0;
        sec  <= '0;
        min  <= '0;
        hour <= '0;
      end else if (load) begin
        msec <= cl_msec;
        sec  <= cl_sec;
        min  <= cl_min;
        hour <= cl_hour;
      end else if (tick) begin
        msec    <= msec_nxt;
        sec     <= sec_nxt;
        min     <= min_nxt;
        hour    <= hour_nxt;
        wrap    <= up_wrap;
        expired <= dn_expire;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap latches the time shown before this edge's update; clear wins when both arrive together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_msec <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      lap_hour <= '0;
    end else if (clear) begin
      lap_msec <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      lap_hour <= '0;
    end else if (lap) begin
      lap_msec <= msec;
      lap_sec  <= sec;
      lap_min  <= min;
      lap_hour <= hour;
    end
  end
`else
  assign lap_msec = '0;
  assign lap_sec  = '0;
  assign lap_min  = '0;
  assign lap_hour = '0;
`endif

endmodule
